// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer mode (CPOL/CPHA), bit order, SCLK divider and chip-select.
// All per-transfer settings are captured when a start is accepted in IDLE.
module spi_master_cfg #(
    parameter int unsigned DW   = 16,
    parameter int unsigned DIVW = 8,
    parameter int unsigned NCS  = 1,
    localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   din,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            lsb_first,
    input  logic [DIVW-1:0] div,
    input  logic [CSW-1:0]  cs_sel,
    input  logic            miso,
    output logic            sclk,
    output logic            mosi,
    output logic            mosi_oe,
    output logic [NCS-1:0]  cs_n,
    output logic [DW-1:0]   dout,
    output logic            busy,
    output logic            done
);
    localparam int unsigned HPW = $clog2(2 * DW);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [HPW-1:0]  hp_q, hp_d;
    logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic            cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, sclk_q, sclk_d;
    logic [CSW-1:0]  cs_q, cs_d;
    logic            hp_end, do_sample, do_shift, lead_edge, active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            hp_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            hp_q    <= hp_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        hp_d      = hp_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        hp_end    = (cnt_q == div_q);
        // hp_q odd means the next SCLK toggle starts an even half-period: a leading edge
        lead_edge = hp_q[0];

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    state_d = S_LEAD;
                    tx_d    = din;
                    rx_d    = '0;
                    cnt_d   = '0;
                    hp_d    = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    div_d   = div;
                    cs_d    = cs_sel;
                end
            end
            S_LEAD: begin
                if (hp_end) begin
                    state_d   = S_XFER;
                    cnt_d     = '0;
                    hp_d      = '0;
                    sclk_d    = ~sclk_q;
                    // first bit is already on mosi, so CPHA=1 does not shift here
                    do_sample = ~cpha_q;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            S_XFER: begin
                if (hp_end) begin
                    cnt_d = '0;
                    if (hp_q == HPW'(2 * DW - 1)) begin
                        state_d = S_TRAIL;
                    end else begin
                        hp_d      = hp_q + HPW'(1);
                        sclk_d    = ~sclk_q;
                        do_sample = lead_edge ^ cpha_q;
                        do_shift  = ~(lead_edge ^ cpha_q);
                    end
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            S_TRAIL: begin
                if (hp_end) begin
                    state_d = S_DONE;
                    dout_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                sclk_d  = cpol;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_sample)
            rx_d = lsb_q ? {miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], miso};
        if (do_shift)
            tx_d = lsb_q ? {1'b0, tx_q[DW-1:1]} : {tx_q[DW-2:0], 1'b0};
    end

    always_comb begin
        active = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
        cs_n   = '1;
        for (int unsigned i = 0; i < NCS; i++)
            cs_n[i] = ~(active && (cs_q == CSW'(i)));
        mosi_oe = ~&cs_n;
        mosi    = mosi_oe & (lsb_q ? tx_q[0] : tx_q[DW-1]);
        sclk    = sclk_q;
        dout    = dout_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end
endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 Parameter DW, default 16, shift-register and data word width in bits (2..64).
REQ-002 Parameter DIVW, default 8, width of the SCLK divider input.
REQ-003 Parameter NCS, default 1, number of chip-select outputs (1..8); CSW = max(1, clog2(NCS)).
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  request a transfer; sampled only while busy=0.
REQ-007 Port din  input  DW  transmit word; latched at start acceptance.
REQ-008 Port cpol  input  1  SCLK idle level; latched at start acceptance.
REQ-009 Port cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched at start acceptance.
REQ-010 Port lsb_first  input  1  0: MSB first; 1: LSB first; latched at start acceptance.
REQ-011 Port div  input  DIVW  SCLK half-period = div+1 clk cycles; latched at start acceptance.
REQ-012 Port cs_sel  input  CSW  chip-select index; latched at start acceptance.
REQ-013 Port miso  input  1  serial data from slave.
REQ-014 Port sclk  output  1  serial clock.
REQ-015 Port mosi  output  1  serial data to slave.
REQ-016 Port mosi_oe  output  1  mosi drive enable for the external tri-state.
REQ-017 Port cs_n  output  NCS  active-low chip selects.
REQ-018 Port dout  output  DW  last received word; holds between transfers.
REQ-019 Port busy  output  1  transfer in progress.
REQ-020 Port done  output  1  one-cycle pulse at end of transfer.

Function
REQ-021 FSM states IDLE, LEAD, XFER, TRAIL, DONE; IDLE->LEAD on start=1 in IDLE (cycle T0), with parameters latched at T0.
REQ-022 LEAD: div+1 cycles (T1..); cs_n[cs_sel]=0, sclk=cpol, first tx bit on mosi; then XFER.
REQ-023 XFER: 2*DW half-periods of div+1 cycles each; sclk toggles at each half-period boundary, ending at cpol; then TRAIL.
REQ-024 cpha=0: miso sampled on leading edges, mosi advances on trailing edges; cpha=1: mosi advances on leading edges (first bit driven at the first leading edge), miso sampled on trailing edges.
REQ-025 Bit order follows latched lsb_first for both tx and rx; rx word assembled to the same significance as tx.
REQ-026 TRAIL: div+1 cycles, cs_n held asserted, sclk=cpol; then DONE.
REQ-027 DONE: one cycle; cs_n all 1, done=1, dout updated with received word; next state IDLE.
REQ-028 done asserted at cycle T1+(div+1)*(2*DW+2); busy=1 from T1 through the DONE cycle inclusive, 0 otherwise.
REQ-029 start while busy=1 (including the DONE cycle) is ignored; no queueing.
REQ-030 Input changes on din/cpol/cpha/lsb_first/div/cs_sel during busy have no effect on the current transfer.
REQ-031 cs_sel >= NCS: transfer runs with full timing, all cs_n stay 1, dout still updated.
REQ-032 mosi_oe=1 exactly while any cs_n bit is 0; mosi=0 whenever mosi_oe=0.
REQ-033 div=0 is legal: sclk frequency clk/2.
REQ-034 In IDLE sclk follows the current cpol input (registered, one-cycle delay).

Reset
REQ-035 On rst=0, immediately and asynchronously: state IDLE, sclk=0, mosi=0, mosi_oe=0, cs_n all 1, dout=0, busy=0, done=0.
REQ-036 Reset mid-transfer aborts without a done pulse; dout keeps the reset value 0.
REQ-037 After rst deasserts, the first start is accepted on the next rising edge.

Verification
REQ-038 DW=16, div=0, cpol=0, cpha=0, MSB first, din=16'hA53C, miso looped to mosi -> dout=16'hA53C, done at T1+34, 16 rising sclk edges.
REQ-039 cpol=1, cpha=1, div=2, din=16'h00FF, miso tied 1 -> sclk idle 1, half-period 3 cycles, dout=16'hFFFF, done at T1+102.
REQ-040 lsb_first=1, din=16'h0001, loopback -> first mosi bit 1, dout=16'h0001.
REQ-041 start pulsed at T1+5 and in DONE cycle -> ignored; exactly one done pulse; busy low the cycle after DONE.
REQ-042 rst=0 at T1+10 -> cs_n all 1, sclk=0, busy=0 within the same cycle, no done, dout=0.
REQ-043 NCS=3, cs_sel=3 -> cs_n stays 3'b111, mosi_oe=0 throughout, done at normal time.
